clos_cfg_alloc: RTL

Synchronous configuration allocator for the data Clos switch: accepts per-virtual-circuit route requests from the five input ports, allocates a free central module (CM) path, and drives the IM crossbar configuration plus the per-CM XY-turn configuration. It releases the path on end-of-frame. It is the controlling end of the `imcfg`/`scfg`/`ncfg`/`wcfg`/`ecfg`/`lcfg` interface consumed by the Clos data path. Every configuration bit it drives is registered and glitch-free.

---
 rtl/clos_pkg.sv | 68 ++++++
 rtl/rr_arb.sv | 42 ++++
 rtl/clos_cfg_alloc.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/clos_pkg.sv
// Shared types and routing helpers for the Clos configuration allocator.
package clos_pkg;

    localparam int unsigned NPORT = 5;
    localparam int unsigned DW    = 3;

    // Port / output direction encoding.
    typedef enum logic [DW-1:0] {
        DIR_S = 3'd0,
        DIR_W = 3'd1,
        DIR_N = 3'd2,
        DIR_E = 3'd3,
        DIR_L = 3'd4
    } dir_e;

    // XY routing: may traffic entering on in_dir leave on out_dir?
    function automatic logic legal_turn(input logic [DW-1:0] in_dir, input logic [DW-1:0] out_dir);
        logic ok;
        ok = 1'b0;
        case (out_dir)
            DIR_S:   ok = (in_dir == DIR_N) || (in_dir == DIR_L);
            DIR_N:   ok = (in_dir == DIR_S) || (in_dir == DIR_L);
            DIR_W:   ok = (in_dir != DIR_W) && (in_dir <= DIR_L);
            DIR_E:   ok = (in_dir != DIR_E) && (in_dir <= DIR_L);
            DIR_L:   ok = (in_dir == DIR_S) || (in_dir == DIR_W) ||
                          (in_dir == DIR_N) || (in_dir == DIR_E);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Bit position of input in_dir within the cfg vector of output out_dir.
    function automatic logic [1:0] cmcfg_bit(input logic [DW-1:0] out_dir, input logic [DW-1:0] in_dir);
        logic [1:0] b;
        b = 2'd0;
        case (out_dir)
            DIR_S:   b = (in_dir == DIR_L) ? 2'd1 : 2'd0;
            DIR_N:   b = (in_dir == DIR_L) ? 2'd1 : 2'd0;
            DIR_W: begin
                case (in_dir)
                    DIR_N:   b = 2'd1;
                    DIR_E:   b = 2'd2;
                    DIR_L:   b = 2'd3;
                    default: b = 2'd0;
                endcase
            end
            DIR_E: begin
                case (in_dir)
                    DIR_W:   b = 2'd1;
                    DIR_N:   b = 2'd2;
                    DIR_L:   b = 2'd3;
                    default: b = 2'd0;
                endcase
            end
            DIR_L: begin
                case (in_dir)
                    DIR_W:   b = 2'd1;
                    DIR_N:   b = 2'd2;
                    DIR_E:   b = 2'd3;
                    default: b = 2'd0;
                endcase
            end
            default: b = 2'd0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: one-hot grant from i_ptr upward, pointer moves past the winner.
module rr_arb #(
    parameter int unsigned N  = 10,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt_c,
    output logic [PW-1:0] o_ptr_nxt_c
);

    // Modulo-N add of a small offset to a pointer value.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return PW'(s);
    endfunction

    logic          w_found;
    logic [PW-1:0] w_win;

    // Scan requesters starting at the pointer, first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = i_ptr;
        o_gnt_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!w_found && i_req[wrap_add(i_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(i_ptr, k);
            end
        end
        if (w_found) begin
            o_gnt_c[w_win] = 1'b1;
        end
        o_ptr_nxt_c = w_found ? wrap_add(w_win, 1) : i_ptr;
    end

endmodule

// File: rtl/clos_cfg_alloc.sv
// Central-module path allocator: grants per-VC routes and drives IM crossbar and CM turn configuration.
module clos_cfg_alloc
    import clos_pkg::*;
#(
    parameter int unsigned MN = 2,
    parameter int unsigned NN = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NPORT-1:0][NN-1:0]                  req,
    input  logic [NPORT-1:0][NN-1:0][2:0]             rdir,
    input  logic [NPORT-1:0][NN-1:0]                  rel,
    output logic [NPORT-1:0][NN-1:0]                  gnt,
    output logic [NPORT-1:0][NN-1:0][$clog2(MN)-1:0]  gcm,
    output logic                                      err,
    output logic [NPORT-1:0][MN-1:0][NN-1:0]          imcfg,
    output logic [MN-1:0][1:0]                        scfg,
    output logic [MN-1:0][1:0]                        ncfg,
    output logic [MN-1:0][3:0]                        wcfg,
    output logic [MN-1:0][3:0]                        ecfg,
    output logic [MN-1:0][3:0]                        lcfg
);

    localparam int unsigned CW   = $clog2(MN);
    localparam int unsigned NREQ = NPORT * NN;
    localparam int unsigned PW   = $clog2(NREQ);

    // Registered state
    logic [NPORT-1:0][NN-1:0]          r_gnt,   w_gnt_nxt;
    logic [NPORT-1:0][NN-1:0][CW-1:0]  r_gcm,   w_gcm_nxt;
    logic [NPORT-1:0][NN-1:0][DW-1:0]  r_dir,   w_dir_nxt;
    logic [NPORT-1:0][NN-1:0]          r_drop,  w_drop_nxt;
    logic [NPORT-1:0][MN-1:0]          r_lbusy, w_lbusy_nxt;
    logic [NPORT-1:0][MN-1:0]          r_obusy, w_obusy_nxt;
    logic [NPORT-1:0][MN-1:0][NN-1:0]  r_imcfg, w_imcfg_nxt;
    logic [MN-1:0][1:0]                r_scfg,  w_scfg_nxt;
    logic [MN-1:0][1:0]                r_ncfg,  w_ncfg_nxt;
    logic [MN-1:0][3:0]                r_wcfg,  w_wcfg_nxt;
    logic [MN-1:0][3:0]                r_ecfg,  w_ecfg_nxt;
    logic [MN-1:0][3:0]                r_lcfg,  w_lcfg_nxt;
    logic                              r_err,   w_err_nxt;
    logic [PW-1:0]                     r_ptr,   w_ptr_nxt;

    // Combinational helpers
    logic [NPORT-1:0][NN-1:0]          w_elig;
    logic [NPORT-1:0][NN-1:0]          w_illegal;
    logic [NPORT-1:0][NN-1:0][CW-1:0]  w_cm;
    logic [NREQ-1:0]                   w_arb_req;
    logic [NREQ-1:0]                   w_arb_gnt;
    logic [NPORT-1:0][NN-1:0]          w_gsel;
    logic                              w_upd;
    logic                              w_val;
    logic [DW-1:0]                     w_d;
    logic [CW-1:0]                     w_m;
    logic [1:0]                        w_b;

    // Classify pending requests as illegal or eligible, and pick the lowest free CM.
    always_comb begin
        w_elig    = '0;
        w_illegal = '0;
        w_cm      = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            for (int unsigned n = 0; n < NN; n++) begin
                if (req[p][n] && !r_gnt[p][n] && !r_drop[p][n]) begin
                    if (!legal_turn(3'(p), rdir[p][n])) begin
                        w_illegal[p][n] = 1'b1;
                    end else begin
                        for (int unsigned m = 0; m < MN; m++) begin
                            if (!w_elig[p][n] && !r_lbusy[p][m] && !r_obusy[rdir[p][n]][m]) begin
                                w_elig[p][n] = 1'b1;
                                w_cm[p][n]   = CW'(m);
                            end
                        end
                    end
                end
            end
        end
    end

    assign w_arb_req = w_elig;
    assign w_gsel    = w_arb_gnt;

    rr_arb #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_arb (
        .i_req       (w_arb_req),
        .i_ptr       (r_ptr),
        .o_gnt_c     (w_arb_gnt),
        .o_ptr_nxt_c (w_ptr_nxt)
    );

    // Next state: releases clear their resources, then the single winner claims its own.
    always_comb begin
        w_gnt_nxt   = r_gnt;
        w_gcm_nxt   = r_gcm;
        w_dir_nxt   = r_dir;
        w_drop_nxt  = r_drop;
        w_lbusy_nxt = r_lbusy;
        w_obusy_nxt = r_obusy;
        w_imcfg_nxt = r_imcfg;
        w_scfg_nxt  = r_scfg;
        w_ncfg_nxt  = r_ncfg;
        w_wcfg_nxt  = r_wcfg;
        w_ecfg_nxt  = r_ecfg;
        w_lcfg_nxt  = r_lcfg;
        w_err_nxt   = |w_illegal;
        w_upd       = 1'b0;
        w_val       = 1'b0;
        w_d         = '0;
        w_m         = '0;
        w_b         = '0;

        // An illegal request stays dropped until req is seen low.
        for (int unsigned p = 0; p < NPORT; p++) begin
            for (int unsigned n = 0; n < NN; n++) begin
                if (!req[p][n]) begin
                    w_drop_nxt[p][n] = 1'b0;
                end else if (w_illegal[p][n]) begin
                    w_drop_nxt[p][n] = 1'b1;
                end
            end
        end

        // Phase 0 releases (value 0), phase 1 allocates (value 1); resources are disjoint.
        for (int unsigned ph = 0; ph < 2; ph++) begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                for (int unsigned n = 0; n < NN; n++) begin
                    w_upd = (ph == 0) ? (rel[p][n] && r_gnt[p][n]) : w_gsel[p][n];
                    w_val = (ph != 0);
                    w_d   = (ph == 0) ? r_dir[p][n] : rdir[p][n];
                    w_m   = (ph == 0) ? r_gcm[p][n] : w_cm[p][n];
                    if (w_upd) begin
                        w_b = cmcfg_bit(w_d, 3'(p));
                        w_imcfg_nxt[p][w_m][n] = w_val;
                        w_lbusy_nxt[p][w_m]    = w_val;
                        w_obusy_nxt[w_d][w_m]  = w_val;
                        w_gnt_nxt[p][n]        = w_val;
                        w_gcm_nxt[p][n]        = w_val ? w_m : '0;
                        w_dir_nxt[p][n]        = w_val ? w_d : '0;
                        case (w_d)
                            DIR_S:   w_scfg_nxt[w_m][w_b[0]] = w_val;
                            DIR_N:   w_ncfg_nxt[w_m][w_b[0]] = w_val;
                            DIR_W:   w_wcfg_nxt[w_m][w_b]    = w_val;
                            DIR_E:   w_ecfg_nxt[w_m][w_b]    = w_val;
                            DIR_L:   w_lcfg_nxt[w_m][w_b]    = w_val;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // State register; reset drops every path at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= '0;
            r_gcm   <= '0;
            r_dir   <= '0;
            r_drop  <= '0;
            r_lbusy <= '0;
            r_obusy <= '0;
            r_imcfg <= '0;
            r_scfg  <= '0;
            r_ncfg  <= '0;
            r_wcfg  <= '0;
            r_ecfg  <= '0;
            r_lcfg  <= '0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_gcm   <= w_gcm_nxt;
            r_dir   <= w_dir_nxt;
            r_drop  <= w_drop_nxt;
            r_lbusy <= w_lbusy_nxt;
            r_obusy <= w_obusy_nxt;
            r_imcfg <= w_imcfg_nxt;
            r_scfg  <= w_scfg_nxt;
            r_ncfg  <= w_ncfg_nxt;
            r_wcfg  <= w_wcfg_nxt;
            r_ecfg  <= w_ecfg_nxt;
            r_lcfg  <= w_lcfg_nxt;
            r_err   <= w_err_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign gcm   = r_gcm;
    assign err   = r_err;
    assign imcfg = r_imcfg;
    assign scfg  = r_scfg;
    assign ncfg  = r_ncfg;
    assign wcfg  = r_wcfg;
    assign ecfg  = r_ecfg;
    assign lcfg  = r_lcfg;

    // One driver per IM link and per CM output channel.
    for (genvar ap = 0; ap < NPORT; ap++) begin : g_im_chk
        for (genvar am = 0; am < MN; am++) begin : g_im_m
            a_im_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_imcfg[ap][am]));
        end
    end

    for (genvar am = 0; am < MN; am++) begin : g_cm_chk
        a_s_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_scfg[am]));
        a_n_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_ncfg[am]));
        a_w_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_wcfg[am]));
        a_e_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_ecfg[am]));
        a_l_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_lcfg[am]));
    end

endmodule
